// File: rtl/servo_pkg.sv
// Shared constants, angle type and the per-frame slew helper for the servo PWM bank.
package servo_pkg;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_PERIOD_CYC  = 480000;
  localparam int DEF_MIN_PULSE   = 12000;
  localparam int DEF_CYC_PER_DEG = 267;
  localparam int ANGLE_W         = 8;
  localparam int DEF_MAX_ANGLE   = 180;
  localparam int DEF_SLEW_DEG    = 5;
  localparam int DEF_RESET_ANGLE = 90;

  typedef logic [ANGLE_W-1:0] angle_t;

  // Next applied angle: step toward target by at most slew degrees; slew of 0 jumps.
  function automatic logic [31:0] slew_step(input logic [31:0] applied,
                                            input logic [31:0] target,
                                            input logic [31:0] slew);
    logic [31:0] diff;
    logic [31:0] result;
    result = target;
    if (slew != 32'd0) begin
      if (target >= applied) begin
        diff = target - applied;
        if (diff > slew) result = applied + slew;
      end else begin
        diff = applied - target;
        if (diff > slew) result = applied - slew;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: holds target/applied angle and the frame-latched pulse width.
import servo_pkg::*;

module servo_channel #(
  parameter int ANGLE_W     = servo_pkg::ANGLE_W,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int CYC_PER_DEG = DEF_CYC_PER_DEG,
  parameter int SLEW_DEG    = DEF_SLEW_DEG,
  parameter int RESET_ANGLE = DEF_RESET_ANGLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        i_counter,
  input  logic               i_commit,
  input  logic               i_we,
  input  logic [ANGLE_W-1:0] i_angle,
  output logic               o_pwm,
  output logic               o_moving
);

  localparam logic [ANGLE_W-1:0] RST_ANGLE = ANGLE_W'(RESET_ANGLE);
  localparam logic [31:0]        RST_PULSE = 32'(MIN_PULSE + RESET_ANGLE * CYC_PER_DEG);

  logic [ANGLE_W-1:0] r_target;
  logic [ANGLE_W-1:0] r_applied;
  logic [31:0]        r_pulse_q;
  logic               r_pwm;
  logic               r_moving;
  logic [ANGLE_W-1:0] w_next_applied;
  logic [31:0]        w_next_pulse;

  assign w_next_applied = ANGLE_W'(slew_step(32'(r_applied), 32'(r_target), 32'(SLEW_DEG)));
  assign w_next_pulse   = 32'(MIN_PULSE) + 32'(w_next_applied) * 32'(CYC_PER_DEG);

  // Commit reads r_target before this edge's write lands, so a same-edge write waits a frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_target  <= RST_ANGLE;
      r_applied <= RST_ANGLE;
      r_pulse_q <= RST_PULSE;
      r_pwm     <= 1'b0;
      r_moving  <= 1'b0;
    end else begin
      if (i_commit) begin
        r_applied <= w_next_applied;
        r_pulse_q <= w_next_pulse;
      end
      if (i_we) r_target <= i_angle;
      r_pwm    <= (i_counter < r_pulse_q);
      r_moving <= (r_applied != r_target);
    end
  end

  assign o_pwm    = r_pwm;
  assign o_moving = r_moving;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM: shared frame counter, command handshake with clamp, per-channel slices.
import servo_pkg::*;

module servo_pwm_bank #(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int CYC_PER_DEG = DEF_CYC_PER_DEG,
  parameter int ANGLE_W     = servo_pkg::ANGLE_W,
  parameter int MAX_ANGLE   = DEF_MAX_ANGLE,
  parameter int SLEW_DEG    = DEF_SLEW_DEG,
  parameter int RESET_ANGLE = DEF_RESET_ANGLE,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [CH_W-1:0]    i_cmd_ch,
  input  logic [ANGLE_W-1:0] i_cmd_angle,
  output logic [NUM_CH-1:0]  o_pwm,
  output logic               o_frame_start,
  output logic [NUM_CH-1:0]  o_moving
);

  if (longint'(MIN_PULSE) + longint'(MAX_ANGLE) * longint'(CYC_PER_DEG) >= longint'(PERIOD_CYC))
  begin : g_pulse_overrun
    $error("servo_pwm_bank: pulse width at MAX_ANGLE fills the whole frame");
  end

  logic [31:0]        r_counter;
  logic               r_frame_start;
  logic               r_cmd_ready;
  logic               w_commit;
  logic               w_accept;
  logic               w_ch_ok;
  logic [ANGLE_W-1:0] w_angle;

  assign w_commit = (r_counter == 32'(PERIOD_CYC - 1));
  assign w_accept = i_cmd_valid && r_cmd_ready && reset;
  assign w_ch_ok  = (32'(i_cmd_ch) < 32'(NUM_CH));
  assign w_angle  = (32'(i_cmd_angle) > 32'(MAX_ANGLE)) ? ANGLE_W'(MAX_ANGLE) : i_cmd_angle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_counter     <= 32'd0;
      r_frame_start <= 1'b0;
      r_cmd_ready   <= 1'b0;
    end else begin
      r_counter     <= w_commit ? 32'd0 : r_counter + 32'd1;
      r_frame_start <= (r_counter == 32'd0);
      r_cmd_ready   <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_we;
    assign w_we = w_accept && w_ch_ok && (i_cmd_ch == CH_W'(g));

    servo_channel #(
      .ANGLE_W     (ANGLE_W),
      .MIN_PULSE   (MIN_PULSE),
      .CYC_PER_DEG (CYC_PER_DEG),
      .SLEW_DEG    (SLEW_DEG),
      .RESET_ANGLE (RESET_ANGLE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_counter (r_counter),
      .i_commit  (w_commit),
      .i_we      (w_we),
      .i_angle   (w_angle),
      .o_pwm     (o_pwm[g]),
      .o_moving  (o_moving[g])
    );
  end

  assign o_frame_start = r_frame_start;
  assign o_cmd_ready   = r_cmd_ready;

endmodule
